// File: rtl/sha3_pkg.sv
// Shared widths and FSM state type for the SHA3-512 squeeze stage.
package sha3_pkg;

  localparam int unsigned RATE_W       = 576;
  localparam int unsigned LANE_W       = 64;
  localparam int unsigned DIGEST_LANES = 8;
  localparam int unsigned DIGEST_W     = LANE_W * DIGEST_LANES;
  localparam int unsigned LANE_IDX_W   = 3;

  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(DIGEST_LANES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } sha3_state_e;

endpackage : sha3_pkg

// File: rtl/sha3_squeeze.sv
// SHA3-512 squeeze: captures the rate portion of a permuted Keccak state and
// emits the 512-bit digest as eight 64-bit lanes over a valid/ready stream.
//
// Ports:
//   clk          - sole clock, rising edge
//   rst          - synchronous active-low reset
//   state_in     - rate portion of the state, lane k = state_in[64k+63:64k]
//   state_valid  - state_in valid this cycle
//   state_ready  - block can capture a new state (registered)
//   dout         - current digest lane (registered)
//   dout_valid   - dout holds a valid lane (registered)
//   dout_ready   - sink accepts dout this cycle
//   dout_last    - dout is lane 7 of the digest (registered)
//   busy         - a digest is being emitted (registered)
//
// Build option: define SHA3_SQUEEZE_ZEROIZE_EN to clear the captured digest
// and dout once the final lane has been transferred.
module sha3_squeeze
  import sha3_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [RATE_W-1:0] state_in,
  input  logic              state_valid,
  output logic              state_ready,
  output logic [LANE_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy
);

  sha3_state_e           state_q, state_d;
  logic [LANE_IDX_W-1:0] lane_q, lane_d, lane_nxt;
  logic [DIGEST_W-1:0]   cap_q, cap_d;
  logic [LANE_W-1:0]     dout_d;
  logic                  dout_valid_d, dout_last_d, busy_d, state_ready_d;

  assign lane_nxt = lane_q + LANE_IDX_W'(1);

  // Next-state and next-output logic; every output is the registered copy.
  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    cap_d         = cap_q;
    dout_d        = dout;
    dout_valid_d  = dout_valid;
    dout_last_d   = dout_last;
    busy_d        = busy;
    state_ready_d = state_ready;

    unique case (state_q)
      ST_IDLE: begin
        if (state_valid && state_ready) begin
          // Only the first 512 bits of the rate form the digest.
          cap_d         = state_in[DIGEST_W-1:0];
          lane_d        = '0;
          state_d       = ST_EMIT;
          dout_d        = state_in[LANE_W-1:0];
          dout_valid_d  = 1'b1;
          dout_last_d   = 1'b0;
          busy_d        = 1'b1;
          state_ready_d = 1'b0;
        end
      end
      ST_EMIT: begin
        if (dout_valid && dout_ready) begin
          if (lane_q == LAST_LANE) begin
            state_d       = ST_IDLE;
            lane_d        = '0;
            dout_valid_d  = 1'b0;
            dout_last_d   = 1'b0;
            busy_d        = 1'b0;
            state_ready_d = 1'b1;
`ifdef SHA3_SQUEEZE_ZEROIZE_EN
            cap_d         = '0;
            dout_d        = '0;
`endif
          end else begin
            lane_d      = lane_nxt;
            dout_d      = cap_q[LANE_W*32'(lane_nxt) +: LANE_W];
            dout_last_d = (lane_nxt == LAST_LANE);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      cap_q       <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      dout_last   <= 1'b0;
      busy        <= 1'b0;
      state_ready <= 1'b1;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      cap_q       <= cap_d;
      dout        <= dout_d;
      dout_valid  <= dout_valid_d;
      dout_last   <= dout_last_d;
      busy        <= busy_d;
      state_ready <= state_ready_d;
    end
  end

endmodule : sha3_squeeze

// File: tb/tb_sha3_squeeze.sv
// Self-checking bench for sha3_squeeze: directed scenarios plus randomized
// digests and randomized sink backpressure against a lane-list model.
module tb_sha3_squeeze;

  logic         clk;
  logic         rst;
  logic [575:0] state_in;
  logic         state_valid;
  logic         state_ready;
  logic [63:0]  dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;
  logic         busy;

  int passed;
  int total;

  logic [63:0] exp_lanes [8];

  sha3_squeeze dut (
    .clk         (clk),
    .rst         (rst),
    .state_in    (state_in),
    .state_valid (state_valid),
    .state_ready (state_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_last   (dout_last),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [575:0] rand_state();
    logic [575:0] s;
    s = '0;
    for (int i = 0; i < 18; i++) s[32*i +: 32] = $urandom();
    return s;
  endfunction

  // Reference model: the digest is the eight low lanes, in order, unaltered.
  task automatic model_load(input logic [575:0] s);
    for (int k = 0; k < 8; k++) exp_lanes[k] = s[64*k +: 64];
  endtask

  task automatic test_reset();
    rst = 1'b0; state_valid = 1'b0; dout_ready = 1'b0; state_in = '0;
    step(); step();
    total++; if (dout_valid !== 1'b0) $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (dout !== 64'h0) $display("FAIL reset_dout got=%h exp=0", dout); else passed++;
    total++; if (dout_last !== 1'b0) $display("FAIL reset_dout_last got=%b exp=0", dout_last); else passed++;
    rst = 1'b1;
    step();
    total++; if (state_ready !== 1'b1) $display("FAIL reset_state_ready got=%b exp=1", state_ready); else passed++;
    total++; if (dout_valid !== 1'b0) $display("FAIL idle_dout_valid got=%b exp=0", dout_valid); else passed++;
  endtask

  // Present s for capture and check the one-cycle latency to the first lane.
  task automatic send(input logic [575:0] s);
    int cyc;
    cyc = 0;
    while (state_ready !== 1'b1 && cyc < 50) begin step(); cyc++; end
    total++; if (state_ready !== 1'b1) $display("FAIL send_wait_ready got=%b exp=1", state_ready); else passed++;
    model_load(s);
    state_in = s; state_valid = 1'b1; dout_ready = 1'b0;
    step();
    state_valid = 1'b0;
    total++; if (dout_valid !== 1'b1) $display("FAIL capture_latency got=%b exp=1", dout_valid); else passed++;
    total++; if (state_ready !== 1'b0) $display("FAIL emit_state_ready got=%b exp=0", state_ready); else passed++;
  endtask

  // Drain the digest; stall_lane holds dout_ready low 5 cycles at that lane,
  // rnd randomizes dout_ready, inject drives foreign data on state_in.
  task automatic drain(input int stall_lane, input bit rnd, input bit inject);
    int idx, stall, cyc;
    logic [63:0] last_exp;
    idx = 0; stall = 0; cyc = 0;
    while (idx < 8 && cyc < 300) begin
      if (rnd) dout_ready = 1'($urandom_range(0, 1));
      else if (idx == stall_lane && stall < 5) begin dout_ready = 1'b0; stall++; end
      else dout_ready = 1'b1;
      if (inject) begin state_valid = 1'b1; state_in = rand_state(); end
      total++; if (dout_valid !== 1'b1) $display("FAIL emit_dout_valid lane=%0d got=%b exp=1", idx, dout_valid); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL emit_busy lane=%0d got=%b exp=1", idx, busy); else passed++;
      total++; if (state_ready !== 1'b0) $display("FAIL emit_ready lane=%0d got=%b exp=0", idx, state_ready); else passed++;
      total++; if (dout !== exp_lanes[idx]) $display("FAIL lane_data lane=%0d got=%h exp=%h", idx, dout, exp_lanes[idx]); else passed++;
      total++; if (dout_last !== (idx == 7)) $display("FAIL dout_last lane=%0d got=%b exp=%b", idx, dout_last, (idx == 7)); else passed++;
      last_exp = exp_lanes[idx];
      if (dout_ready) idx++;
      step();
      cyc++;
    end
    total++; if (idx != 8) $display("FAIL drain_timeout lanes=%0d exp=8", idx); else passed++;
    state_valid = 1'b0; dout_ready = 1'b0;
    total++; if (dout_valid !== 1'b0) $display("FAIL done_dout_valid got=%b exp=0", dout_valid); else passed++;
    total++; if (state_ready !== 1'b1) $display("FAIL done_state_ready got=%b exp=1", state_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL done_busy got=%b exp=0", busy); else passed++;
`ifdef SHA3_SQUEEZE_ZEROIZE_EN
    total++; if (dout !== 64'h0) $display("FAIL zeroize_dout got=%h exp=0", dout); else passed++;
`else
    total++; if (dout !== last_exp) $display("FAIL retain_dout got=%h exp=%h", dout, last_exp); else passed++;
`endif
    // Idle sink handshakes must not start anything.
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    total++; if (dout_valid !== 1'b0) $display("FAIL idle_ready_effect got=%b exp=0", dout_valid); else passed++;
  endtask

  task automatic test_basic();
    logic [575:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s[64*k +: 64] = 64'h1111_1111_1111_1111 * 64'(k + 1);
    send(s);
    drain(-1, 1'b0, 1'b0);
    total++; if (exp_lanes[7] !== 64'h8888_8888_8888_8888) $display("FAIL basic_model got=%h exp=8888888888888888", exp_lanes[7]); else passed++;
  endtask

  task automatic test_backpressure();
    send(rand_state());
    drain(3, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_input();
    send(rand_state());
    drain(-1, 1'b1, 1'b1);
    send(rand_state());
    drain(-1, 1'b0, 1'b0);
  endtask

  task automatic test_rate_tail();
    logic [575:0] s;
    s = '0;
    s[575:512] = '1;
    send(s);
    drain(-1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    send(rand_state());
    dout_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if (dout !== exp_lanes[k]) $display("FAIL mid_lane lane=%0d got=%h exp=%h", k, dout, exp_lanes[k]); else passed++;
      step();
    end
    rst = 1'b0;
    step();
    rst = 1'b1; dout_ready = 1'b0;
    total++; if (dout_valid !== 1'b0) $display("FAIL abort_dout_valid got=%b exp=0", dout_valid); else passed++;
    total++; if (dout !== 64'h0) $display("FAIL abort_dout got=%h exp=0", dout); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else passed++;
    step();
    total++; if (dout_valid !== 1'b0) $display("FAIL abort_no_more got=%b exp=0", dout_valid); else passed++;
    send(rand_state());
    drain(-1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      send(rand_state());
      drain(-1, 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    passed = 0; total = 0;
    rst = 1'b0; state_valid = 1'b0; dout_ready = 1'b0; state_in = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_input();
    test_rate_tail();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_sha3_squeeze
